// File: rtl/cpu_run_controller_pkg.sv
// ---------------------------------------------------------------------------
// cpu_run_controller_pkg
//   Shared definitions for the run controller: the sequencing state encoding,
//   the position of the halt flag inside the processor status word, and
//   helpers that size the shared write-address bus from the memory depths.
// ---------------------------------------------------------------------------
package cpu_run_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_RF,
    ST_LOAD_DM,
    ST_LOAD_IM,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int STATUS_HALT_BIT = 0;

  // Address width for a memory of 'depth' words; never narrower than 1 bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int max_depth(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// ---------------------------------------------------------------------------
// cpu_run_controller_if
//   Loader word stream from the host/bench into the run controller.
//   ld_valid : word present on ld_data (driven by master)
//   ld_ready : controller accepts a word this cycle (driven by slave)
//   ld_data  : loader word
//   A word transfers on any cycle with ld_valid & ld_ready.
// ---------------------------------------------------------------------------
interface cpu_run_controller_if #(
  parameter int DATA_W = 32
);
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;

  modport master (output ld_valid, output ld_data, input ld_ready);
  modport slave  (input ld_valid, input ld_data, output ld_ready);
endinterface

// File: rtl/cpu_run_controller_counter.sv
// ---------------------------------------------------------------------------
// run_cycle_counter
//   Counts processor run cycles. Synchronous clear has priority over enable;
//   the count saturates at TIMEOUT. o_tc flags the final permitted cycle
//   (count == TIMEOUT-1) so the controller can stop on that same edge.
//   clk, reset (async, active-low), i_clear, i_enable -> o_count, o_tc
// ---------------------------------------------------------------------------
module run_cycle_counter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  // NOTE: registers are assigned with <= so every flop samples pre-edge
  // values; blocking = here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_W'(TIMEOUT))) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_run_controller.sv
// ---------------------------------------------------------------------------
// cpu_run_controller
//   Sequences one program run: holds the CPU in reset while a loader stream
//   fills the register file, data memory and instruction memory (in that
//   order), then releases the CPU and counts cycles until halt or timeout.
//   Ports:
//     clk, reset (async, active-low), start (pulse, honoured in IDLE/DONE)
//     ld_if      : loader stream (slave side)
//     rf_we/dm_we/im_we, wr_addr, wr_data : registered memory write port
//     cpu_rst    : active-high reset held on the processor
//     cpu_status : processor status, halt flag at STATUS_HALT_BIT
//     busy, done, timeout, cycles : run status
// ---------------------------------------------------------------------------
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int  DATA_W   = 32,
  parameter int  RF_DEPTH = 32,
  parameter int  DM_DEPTH = 256,
  parameter int  IM_DEPTH = 256,
  parameter int  TIMEOUT  = 1000,
  parameter int  CNT_W    = 16,
  localparam int ADDR_W   = addr_width(max_depth(RF_DEPTH, DM_DEPTH, IM_DEPTH))
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  cpu_run_controller_if.slave  ld_if,
  output logic                 rf_we,
  output logic                 dm_we,
  output logic                 im_we,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 cpu_rst,
  input  logic [DATA_W-1:0]    cpu_status,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycles
);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic              r_armed;
  logic              r_rf_we, r_dm_we, r_im_we;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_load, w_xfer, w_start, w_run_active, w_halt;
  logic              w_last_word, w_cnt_tc;
  logic              w_unused_status;
  logic [CNT_W-1:0]  w_count;

  assign w_load = (r_state == ST_LOAD_RF) || (r_state == ST_LOAD_DM) ||
                  (r_state == ST_LOAD_IM);
  assign w_xfer = ld_if.ld_valid & w_load;
  // r_armed is low only for the first edge after reset release, so a start
  // coincident with reset release is dropped.
  assign w_start = start & r_armed & ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // The first RUN cycle still carries the final instruction write; the CPU
  // only leaves reset once that write has landed.
  assign w_run_active = (r_state == ST_RUN) & ~r_im_we;
  assign w_halt       = cpu_status[STATUS_HALT_BIT];
  // Only the halt flag is architecturally meaningful in the status word.
  assign w_unused_status = ^cpu_status;

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_last_word = 1'b0;
    case (r_state)
      ST_LOAD_RF: w_last_word = (r_addr == ADDR_W'(RF_DEPTH - 1));
      ST_LOAD_DM: w_last_word = (r_addr == ADDR_W'(DM_DEPTH - 1));
      ST_LOAD_IM: w_last_word = (r_addr == ADDR_W'(IM_DEPTH - 1));
      default:    w_last_word = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_timeout_nxt = r_timeout;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start) begin
          w_state_nxt   = ST_LOAD_RF;
          w_addr_nxt    = '0;
          w_timeout_nxt = 1'b0;
        end
      end
      ST_LOAD_RF, ST_LOAD_DM, ST_LOAD_IM: begin
        if (w_xfer) begin
          if (w_last_word) begin
            w_addr_nxt = '0;
            if (r_state == ST_LOAD_RF)      w_state_nxt = ST_LOAD_DM;
            else if (r_state == ST_LOAD_DM) w_state_nxt = ST_LOAD_IM;
            else                            w_state_nxt = ST_RUN;
          end else begin
            w_addr_nxt = r_addr + ADDR_W'(1);
          end
        end
      end
      ST_RUN: begin
        // Halt is checked first so a halt on the terminal cycle is not a timeout.
        if (w_run_active) begin
          if (w_halt) begin
            w_state_nxt   = ST_DONE;
            w_timeout_nxt = 1'b0;
          end else if (w_cnt_tc) begin
            w_state_nxt   = ST_DONE;
            w_timeout_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_timeout <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_timeout <= w_timeout_nxt;
      r_armed   <= 1'b1;
    end
  end

  // Registered write port: one strobe per accepted word, one cycle later.
  // Address/data hold their last value between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rf_we   <= 1'b0;
      r_dm_we   <= 1'b0;
      r_im_we   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_rf_we <= w_xfer & (r_state == ST_LOAD_RF);
      r_dm_we <= w_xfer & (r_state == ST_LOAD_DM);
      r_im_we <= w_xfer & (r_state == ST_LOAD_IM);
      if (w_xfer) begin
        r_wr_addr <= r_addr;
        r_wr_data <= ld_if.ld_data;
      end
    end
  end

  run_cycle_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_cycle_counter (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_start),
    .i_enable (w_run_active),
    .o_count  (w_count),
    .o_tc     (w_cnt_tc)
  );

  assign ld_if.ld_ready = w_load;
  assign rf_we          = r_rf_we;
  assign dm_we          = r_dm_we;
  assign im_we          = r_im_we;
  assign wr_addr        = r_wr_addr;
  assign wr_data        = r_wr_data;
  assign cpu_rst        = ~w_run_active;
  assign busy           = w_load | (r_state == ST_RUN);
  assign done           = (r_state == ST_DONE);
  assign timeout        = r_timeout;
  assign cycles         = w_count;

endmodule
